control_sequencer: RTL and testbench

Hardwired control step generator that sits directly upstream of `datapath`. It drives every datapath control strobe through the fetch steps T0–T2 and the execute steps T3–T6 for register-to-register ALU, unary, and MUL/DIV instructions. It is a Moore machine: one control step per clock, with strobes decoded from the registered state and the instruction register contents. It replaces hand-sequenced bench stimulus once the datapath is brought up in a CPU top.

---
 rtl/control_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control-step generator for the datapath: fetch T0-T2, then
// execute steps for binary ALU, unary and MUL/DIV register instructions.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR,
    output logic [15:0] R_out,
    output logic [15:0] R_in,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        IncPC,
    output logic [12:0] alu_op,
    output logic        instr_done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_TRAP
    } state_t;

    typedef enum logic [1:0] {C_BIN, C_UNA, C_MD, C_ILL} cls_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    cls_t       cls;
    state_t     last_next;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    function automatic cls_t classify(input logic [4:0] o);
        if (o <= 5'd8)
            return C_BIN;
        else if (o == 5'd9 || o == 5'd10)
            return C_MD;
        else if (o == 5'd11 || o == 5'd12)
            return C_UNA;
        else
            return C_ILL;
    endfunction

    // Opcode numbering differs from the ALU's one-hot bit order.
    function automatic logic [12:0] alu_dec(input logic [4:0] o);
        case (o)
            5'd0:    return 13'h0004;
            5'd1:    return 13'h0008;
            5'd2:    return 13'h0001;
            5'd3:    return 13'h0002;
            5'd4:    return 13'h0040;
            5'd5:    return 13'h0080;
            5'd6:    return 13'h0100;
            5'd7:    return 13'h0200;
            5'd8:    return 13'h0400;
            5'd9:    return 13'h0010;
            5'd10:   return 13'h0020;
            5'd11:   return 13'h0800;
            5'd12:   return 13'h1000;
            default: return 13'h0000;
        endcase
    endfunction

    function automatic logic [15:0] reg_sel(input logic [3:0] r);
        return 16'h0001 << r;
    endfunction

    assign cls       = classify(op);
    assign last_next = run ? S_T0 : S_IDLE;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (cls == C_ILL) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4:   state_d = (cls == C_UNA) ? last_next : S_T5;
            S_T5:   state_d = (cls == C_BIN) ? last_next : S_T6;
            S_T6:   state_d = last_next;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes depend only on the registered step and IR, never on run.
    always_comb begin
        R_out      = '0;
        R_in       = '0;
        PCout      = 1'b0;
        MDRout     = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Read       = 1'b0;
        IncPC      = 1'b0;
        alu_op     = '0;
        instr_done = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                PCin  = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_BIN: begin
                        R_out = reg_sel(rb);
                        Yin   = 1'b1;
                    end
                    C_MD: begin
                        R_out = reg_sel(ra);
                        Yin   = 1'b1;
                    end
                    C_UNA: begin
                        R_out  = reg_sel(rb);
                        alu_op = alu_dec(op);
                        Zin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_BIN: begin
                        R_out  = reg_sel(rc);
                        alu_op = alu_dec(op);
                        Zin    = 1'b1;
                    end
                    C_MD: begin
                        R_out  = reg_sel(rb);
                        alu_op = alu_dec(op);
                        Zin    = 1'b1;
                    end
                    C_UNA: begin
                        Zlowout    = 1'b1;
                        R_in       = reg_sel(ra);
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                if (cls == C_BIN) begin
                    Zlowout    = 1'b1;
                    R_in       = reg_sel(ra);
                    instr_done = 1'b1;
                end else if (cls == C_MD) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                if (cls == C_MD) begin
                    Zhighout   = 1'b1;
                    HIin       = 1'b1;
                    instr_done = 1'b1;
                end
            end
            default: ;
        endcase
        illegal = illegal_q | ((state_q == S_T3) && (cls == C_ILL));
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction table, run/reset corner
// sequences, and random instruction streams against a step-list model.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] IR;
    logic [15:0] R_out, R_in;
    logic        PCout, MDRout, Zhighout, Zlowout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic        Read, IncPC;
    logic [12:0] alu_op;
    logic        instr_done, illegal;

    typedef struct packed {
        logic [15:0] r_out;
        logic [15:0] r_in;
        logic        pcout, mdrout, zhighout, zlowout;
        logic        pcin, irin, marin, mdrin, yin, zin, hiin, loin;
        logic        read, incpc;
        logic [12:0] alu;
        logic        done;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] ir;
        int          len;
        int          alu_step;
        logic [15:0] rout3;
        logic [15:0] rout4;
        logic [12:0] alu;
        logic [15:0] rin_last;
    } vec_rec_t;

    out_t     act;
    out_t     exp_q[$];
    out_t     cap[8];
    vec_rec_t tbl[6];
    int       alu_bit[13] = '{2, 3, 0, 1, 6, 7, 8, 9, 10, 4, 5, 11, 12};
    int       checks = 0;
    int       errors = 0;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .IR(IR),
        .R_out(R_out), .R_in(R_in),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Read(Read), .IncPC(IncPC), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal)
    );

    assign act = {R_out, R_in, PCout, MDRout, Zhighout, Zlowout,
                  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                  Read, IncPC, alu_op, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_vec(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: the per-step strobe list of one instruction, written from the step tables.
    task automatic build_expect(input logic [31:0] ir);
        int   op, ra, rb, rc;
        out_t s;
        op = int'(ir[31:27]);
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);
        exp_q.delete();
        s = '0; s.pcout = 1; s.marin = 1; s.incpc = 1; s.pcin = 1; exp_q.push_back(s);
        s = '0; s.read = 1; s.mdrin = 1; exp_q.push_back(s);
        s = '0; s.mdrout = 1; s.irin = 1; exp_q.push_back(s);
        if (op > 12) begin
            s = '0; s.ill = 1; exp_q.push_back(s);
        end else if (op == 11 || op == 12) begin
            s = '0; s.r_out = 16'h1 << rb; s.alu = 13'h1 << alu_bit[op]; s.zin = 1; exp_q.push_back(s);
            s = '0; s.zlowout = 1; s.r_in = 16'h1 << ra; s.done = 1; exp_q.push_back(s);
        end else if (op == 9 || op == 10) begin
            s = '0; s.r_out = 16'h1 << ra; s.yin = 1; exp_q.push_back(s);
            s = '0; s.r_out = 16'h1 << rb; s.alu = 13'h1 << alu_bit[op]; s.zin = 1; exp_q.push_back(s);
            s = '0; s.zlowout = 1; s.loin = 1; exp_q.push_back(s);
            s = '0; s.zhighout = 1; s.hiin = 1; s.done = 1; exp_q.push_back(s);
        end else begin
            s = '0; s.r_out = 16'h1 << rb; s.yin = 1; exp_q.push_back(s);
            s = '0; s.r_out = 16'h1 << rc; s.alu = 13'h1 << alu_bit[op]; s.zin = 1; exp_q.push_back(s);
            s = '0; s.zlowout = 1; s.r_in = 16'h1 << ra; s.done = 1; exp_q.push_back(s);
        end
    endtask

    // Starts at a negedge in T0; ends at the negedge after the last step.
    task automatic exec(input logic [31:0] ir, input int drop_step, input bit run_after,
                        input int abort_step);
        int n;
        build_expect(ir);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_vec($sformatf("ir%h_step%0d", ir, i), exp_q[i]);
            cap[i] = act;
            if (i == 0) IR = $urandom;
            if (i == 2) IR = ir;
            if (i == drop_step) run = 1'b0;
            if (i == n - 1) run = run_after;
            if (i == abort_step) begin
                reset = 1'b1;
                tick();
                return;
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] ir;
        logic [4:0]  op;
        int          len, drop, gap;
        bit          keep;
        out_t        trap_v;

        tbl[0] = '{32'h3A1B8000, 6, 4, 16'h0008, 16'h0080, 13'h0200, 16'h0010};
        tbl[1] = '{32'h4A1B8000, 7, 4, 16'h0010, 16'h0008, 13'h0010, 16'h0000};
        tbl[2] = '{32'h5A180000, 5, 3, 16'h0008, 16'h0000, 13'h0800, 16'h0010};
        tbl[3] = '{32'h0F878000, 6, 4, 16'h0001, 16'h8000, 13'h0008, 16'h8000};
        tbl[4] = '{32'h61100000, 5, 3, 16'h0004, 16'h0000, 13'h1000, 16'h0004};
        tbl[5] = '{32'h52C80000, 7, 4, 16'h0020, 16'h0200, 13'h0020, 16'h0000};

        reset = 1'b1;
        run   = 1'b0;
        IR    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset_state", '0);
        run = 1'b1;
        tick();
        check_vec("reset_dominates_run", '0);
        reset = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            exec(tbl[t].ir, -1, 1'b1, -1);
            check_val($sformatf("tbl%0d_rout_t3", t), 32'(cap[3].r_out), 32'(tbl[t].rout3));
            check_val($sformatf("tbl%0d_rout_t4", t), 32'(cap[4].r_out), 32'(tbl[t].rout4));
            check_val($sformatf("tbl%0d_aluop", t), 32'(cap[tbl[t].alu_step].alu), 32'(tbl[t].alu));
            check_val($sformatf("tbl%0d_done_last", t), 32'(cap[tbl[t].len - 1].done), 32'd1);
            check_val($sformatf("tbl%0d_rin_last", t), 32'(cap[tbl[t].len - 1].r_in), 32'(tbl[t].rin_last));
        end

        // Run dropped in T4 of ADD: instruction finishes, then idle.
        exec(32'h01100000 | (32'd6 << 23), 4, 1'b0, -1);
        for (int j = 0; j < 3; j++) begin
            check_vec($sformatf("idle_after_drop%0d", j), '0);
            if (j == 2) run = 1'b1;
            tick();
        end

        // Reset asserted in T4 with run held high.
        exec(32'h00A48000, -1, 1'b1, 4);
        check_vec("idle_after_reset", '0);
        tick();
        check_vec("reset_held_with_run", '0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 40; k++) begin
            op   = 5'($urandom_range(0, 12));
            ir   = {op, 27'($urandom)};
            len  = (op == 5'd9 || op == 5'd10) ? 7 : ((op == 5'd11 || op == 5'd12) ? 5 : 6);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 2)) : -1;
            keep = ($urandom_range(0, 4) != 0);
            exec(ir, drop, keep, -1);
            if (!keep) begin
                gap = int'($urandom_range(1, 3));
                for (int j = 0; j < gap; j++) begin
                    check_vec("rand_idle_gap", '0);
                    if (j == gap - 1) run = 1'b1;
                    tick();
                end
            end
        end

        trap_v = '0;
        trap_v.ill = 1'b1;
        for (int p = 0; p < 2; p++) begin
            ir = (p == 0) ? 32'hF8000000 : {5'($urandom_range(13, 31)), 27'($urandom)};
            exec(ir, -1, 1'b1, -1);
            for (int j = 0; j < 6; j++) begin
                check_vec($sformatf("trap%0d_hold%0d", p, j), trap_v);
                run = 1'($urandom);
                IR  = $urandom;
                tick();
            end
            reset = 1'b1;
            tick();
            check_vec($sformatf("trap%0d_reset_clears", p), '0);
            reset = 1'b0;
            run   = 1'b0;
            tick();
            check_vec($sformatf("trap%0d_idle", p), '0);
            run = 1'b1;
            tick();
        end
        exec(32'h3A1B8000, -1, 1'b0, -1);
        check_vec("final_idle", '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
